uart_fifo_ctrl: RTL and testbench

UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

---
 rtl/uart_fifo_pkg.sv | 34 +++
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the FIFO-buffered UART:
// register map, status/enable bit positions and FSM encodings.
package uart_fifo_pkg;

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_LSR  = 3'd1;
  localparam logic [2:0] REG_DIV  = 3'd2;
  localparam logic [2:0] REG_IER  = 3'd3;
  localparam logic [2:0] REG_LVL  = 3'd4;

  localparam int LSR_RXNE    = 0;
  localparam int LSR_OE      = 1;
  localparam int LSR_FE      = 2;
  localparam int LSR_TXFULL  = 4;
  localparam int LSR_TXEMPTY = 5;
  localparam int LSR_TXIDLE  = 6;

  localparam int IER_RX  = 0;
  localparam int IER_TX  = 1;
  localparam int IER_ERR = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_st_e;

  // Divisors below 2 would leave no room for a mid-bit sample.
  function automatic logic [15:0] bit_period(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; storage is not reset,
// only the pointers and count are.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// FIFO-buffered UART with a small register bus, independent
// TX/RX bit timers and a registered level interrupt.
module uart_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd5208
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [4:2]  ADD_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  input  logic        RxD,
  output logic        TxD,
  output logic        IRQ
);

  localparam int DB = DATA_BITS;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic wr_data, rd_data, rd_lsr, wr_div, wr_ier;
  logic [15:0] div_q, div_d, per_now;
  logic [2:0]  ier_q, ier_d;
  logic fe_q, fe_d, oe_q, oe_d, irq_q, irq_d;
  logic fe_set, oe_set;

  logic tx_pop, tx_full, tx_empty, tx_idle, tx_load, tx_tick;
  logic [DB-1:0] tx_dout;
  logic [CW-1:0] tx_count;
  uart_st_e      tx_st_q, tx_st_d;
  logic [15:0]   tx_cnt_q, tx_cnt_d, tx_per_q, tx_per_d;
  logic [DB-1:0] tx_sh_q, tx_sh_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic          txd_q, txd_d;

  logic rx_push, rx_full, rx_empty, rx_fall, rx_tick;
  logic [DB-1:0] rx_dout;
  logic [CW-1:0] rx_count;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  uart_st_e      rx_st_q, rx_st_d;
  logic [15:0]   rx_cnt_q, rx_cnt_d, rx_per_q, rx_per_d;
  logic [DB-1:0] rx_sh_q, rx_sh_d;
  logic [2:0]    rx_bit_q, rx_bit_d;

  logic unused_dat;
  assign unused_dat = ^DAT_I[31:16];

  assign ACK_O   = STB_I;
  assign TxD     = txd_q;
  assign IRQ     = irq_q;
  assign wr_data = STB_I & WE_I & (ADD_I == REG_DATA);
  assign rd_data = STB_I & ~WE_I & (ADD_I == REG_DATA);
  assign rd_lsr  = STB_I & ~WE_I & (ADD_I == REG_LSR);
  assign wr_div  = STB_I & WE_I & (ADD_I == REG_DIV);
  assign wr_ier  = STB_I & WE_I & (ADD_I == REG_IER);
  assign per_now = bit_period(div_q);
  assign tx_idle = tx_empty & (tx_st_q == ST_IDLE);

  uart_sync_fifo #(.WIDTH(DB), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(CLK_I), .rst(RST_I),
    .push(wr_data), .pop(tx_pop),
    .din(DAT_I[DB-1:0]), .dout(tx_dout),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(DB), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(CLK_I), .rst(RST_I),
    .push(rx_push), .pop(rd_data),
    .din(rx_sh_q), .dout(rx_dout),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      REG_DATA: if (!rx_empty) DAT_O[DB-1:0] = rx_dout;
      REG_LSR: begin
        DAT_O[LSR_RXNE]    = ~rx_empty;
        DAT_O[LSR_OE]      = oe_q;
        DAT_O[LSR_FE]      = fe_q;
        DAT_O[LSR_TXFULL]  = tx_full;
        DAT_O[LSR_TXEMPTY] = tx_empty;
        DAT_O[LSR_TXIDLE]  = tx_idle;
      end
      REG_DIV: DAT_O[15:0] = div_q;
      REG_IER: DAT_O[2:0]  = ier_q;
      REG_LVL: DAT_O = {16'(rx_count), 16'(tx_count)};
      default: DAT_O = '0;
    endcase
  end

  // Each character latches its own period so DIV writes land cleanly.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_per_d = tx_per_q;
    tx_sh_d  = tx_sh_q;
    tx_bit_d = tx_bit_q;
    txd_d    = txd_q;
    tx_tick  = (tx_cnt_q == 16'd0);
    tx_load  = ~tx_empty &
               ((tx_st_q == ST_IDLE) | ((tx_st_q == ST_STOP) & tx_tick));
    tx_pop   = tx_load;
    if (tx_load) begin
      tx_st_d  = ST_START;
      txd_d    = 1'b0;
      tx_sh_d  = tx_dout;
      tx_per_d = per_now;
      tx_cnt_d = per_now - 16'd1;
    end else begin
      unique case (tx_st_q)
        ST_IDLE: txd_d = 1'b1;
        ST_START, ST_DATA: begin
          if (tx_tick) begin
            tx_cnt_d = tx_per_q - 16'd1;
            if (tx_st_q == ST_DATA && tx_bit_q == LAST_BIT) begin
              tx_st_d = ST_STOP;
              txd_d   = 1'b1;
            end else begin
              tx_bit_d = (tx_st_q == ST_START) ? 3'd0 : tx_bit_q + 3'd1;
              tx_st_d  = ST_DATA;
              txd_d    = tx_sh_q[0];
              tx_sh_d  = tx_sh_q >> 1;
            end
          end else begin
            tx_cnt_d = tx_cnt_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (tx_tick) tx_st_d = ST_IDLE;
          else tx_cnt_d = tx_cnt_q - 16'd1;
        end
        default: tx_st_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_per_d = rx_per_q;
    rx_sh_d  = rx_sh_q;
    rx_bit_d = rx_bit_q;
    rx_push  = 1'b0;
    fe_set   = 1'b0;
    oe_set   = 1'b0;
    rx_fall  = rx_prev_q & ~rx_s2_q;
    rx_tick  = (rx_cnt_q == 16'd0);
    unique case (rx_st_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_st_d  = ST_START;
          rx_per_d = per_now;
          rx_cnt_d = (per_now >> 1) - 16'd1;
        end
      end
      ST_START: begin
        if (!rx_tick) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (rx_s2_q) begin
          rx_st_d = ST_IDLE;
        end else begin
          rx_st_d  = ST_DATA;
          rx_bit_d = 3'd0;
          rx_cnt_d = rx_per_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_tick) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[DB-1:1]};
          rx_cnt_d = rx_per_q - 16'd1;
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == LAST_BIT) rx_st_d = ST_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (rx_tick) begin
          rx_st_d = ST_IDLE;
          if (!rx_s2_q) fe_set = 1'b1;
          else if (rx_full) oe_set = 1'b1;
          else rx_push = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_d = wr_div ? DAT_I[15:0] : div_q;
    ier_d = wr_ier ? DAT_I[2:0] : ier_q;
    fe_d  = fe_set | (fe_q & ~rd_lsr);
    oe_d  = oe_set | (oe_q & ~rd_lsr);
    irq_d = (ier_q[IER_RX] & ~rx_empty) |
            (ier_q[IER_TX] & tx_empty) |
            (ier_q[IER_ERR] & (oe_q | fe_q));
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      div_q     <= DIV_RESET;
      ier_q     <= '0;
      fe_q      <= 1'b0;
      oe_q      <= 1'b0;
      irq_q     <= 1'b0;
      tx_st_q   <= ST_IDLE;
      tx_cnt_q  <= '0;
      tx_per_q  <= 16'd2;
      tx_sh_q   <= '0;
      tx_bit_q  <= '0;
      txd_q     <= 1'b1;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= ST_IDLE;
      rx_cnt_q  <= '0;
      rx_per_q  <= 16'd2;
      rx_sh_q   <= '0;
      rx_bit_q  <= '0;
    end else begin
      div_q     <= div_d;
      ier_q     <= ier_d;
      fe_q      <= fe_d;
      oe_q      <= oe_d;
      irq_q     <= irq_d;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_per_q  <= tx_per_d;
      tx_sh_q   <= tx_sh_d;
      tx_bit_q  <= tx_bit_d;
      txd_q     <= txd_d;
      rx_s1_q   <= RxD;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_per_q  <= rx_per_d;
      rx_sh_q   <= rx_sh_d;
      rx_bit_q  <= rx_bit_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scenario bench for uart_fifo_ctrl: random serial traffic checked
// against queue-based models of the FIFOs and the line protocol.
module tb_uart_fifo_ctrl;
  import uart_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] add = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic stb = 1'b0;
  logic we = 1'b0;
  logic ack;
  logic rxd = 1'b1;
  logic txd;
  logic irq;
  int pass_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_fifo_ctrl dut (
    .CLK_I(clk), .RST_I(rst), .ADD_I(add), .DAT_I(dat_i),
    .DAT_O(dat_o), .STB_I(stb), .WE_I(we), .ACK_O(ack),
    .RxD(rxd), .TxD(txd), .IRQ(irq)
  );

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    add = a; dat_i = d; we = 1'b1; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    add = a; we = 1'b0; stb = 1'b1;
    #1 d = dat_o;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stp, input int per);
    @(negedge clk);
    rxd = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (per) @(negedge clk);
    end
    rxd = stp;
    repeat (per) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Line-level receiver watching TxD; t0 is the start-bit cycle.
  task automatic tx_decode(input int per, output logic [7:0] b,
                           output int t0, output bit ok);
    int n;
    n = 0; ok = 1'b1; b = '0; t0 = 0;
    while (txd !== 1'b0 && n < 40 * per) begin
      @(negedge clk);
      n++;
    end
    if (txd !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    t0 = cyc;
    repeat (per / 2) @(negedge clk);
    if (txd !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (per) @(negedge clk);
      b[i] = txd;
    end
    repeat (per) @(negedge clk);
    if (txd !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (txd !== 1'b1 || irq !== 1'b0)
      $display("FAIL reset_pins: txd=%b irq=%b exp 1/0", txd, irq);
    else pass_cnt++;
    rst = 1'b0;
    bus_rd(REG_LSR, r);
    chk_cnt++;
    if (r !== 32'h60) $display("FAIL reset_lsr: got %h exp 60", r);
    else pass_cnt++;
    bus_rd(REG_DIV, r);
    chk_cnt++;
    if (r !== 32'd5208) $display("FAIL reset_div: got %0d exp 5208", r);
    else pass_cnt++;
    bus_rd(REG_IER, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL reset_ier: got %h exp 0", r);
    else pass_cnt++;
    bus_rd(REG_DATA, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL empty_read: got %h exp 0", r);
    else pass_cnt++;
    bus_rd(REG_LVL, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL reset_lvl: got %h exp 0", r);
    else pass_cnt++;
    bus_wr(3'd5, 32'hFFFF_FFFF);
    bus_rd(3'd5, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL unmapped: got %h exp 0", r);
    else pass_cnt++;
  endtask

  task automatic test_tx_pattern();
    logic [9:0] frame;
    logic [31:0] r;
    int n;
    bit ok;
    frame = {1'b1, 8'hA5, 1'b0};
    bus_wr(REG_DIV, 32'd4);
    bus_wr(REG_DATA, 32'hA5);
    n = 0;
    while (txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        if (txd !== frame[b]) ok = 1'b0;
      end
      chk_cnt++;
      if (!ok) $display("FAIL tx_a5_bit%0d: txd=%b exp %b for 4 clks",
                        b, txd, frame[b]);
      else pass_cnt++;
    end
    bus_rd(REG_LSR, r);
    chk_cnt++;
    if (r[LSR_TXIDLE] !== 1'b1 || r[LSR_TXEMPTY] !== 1'b1)
      $display("FAIL tx_idle_after: lsr=%h exp bits6,5 set", r);
    else pass_cnt++;
  endtask

  task automatic test_tx_random();
    logic [7:0] exp_q[$];
    logic [7:0] got[5];
    int t[5];
    bit ok[5];
    logic [7:0] v;
    bus_wr(REG_DIV, 32'd16);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          v = 8'($urandom);
          exp_q.push_back(v);
          bus_wr(REG_DATA, {24'h0, v});
        end
      end
      begin
        for (int i = 0; i < 5; i++) tx_decode(16, got[i], t[i], ok[i]);
      end
    join
    for (int i = 0; i < 5; i++) begin
      chk_cnt++;
      if (!ok[i] || got[i] !== exp_q[i])
        $display("FAIL tx_rand%0d: got %h ok=%b exp %h", i, got[i], ok[i], exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (t[4] - t[0] !== 4 * 160)
      $display("FAIL tx_rand_spacing: span %0d exp %0d", t[4] - t[0], 640);
    else pass_cnt++;
  endtask

  // The transmitter takes the first byte as soon as it lands, so the
  // FIFO then absorbs 16 more and only the 18th write is dropped.
  task automatic test_tx_overflow();
    logic [7:0] got[18];
    int t[18];
    bit ok[18];
    logic [31:0] lvl, lsr;
    int gaps;
    repeat (20) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 18; i++) bus_wr(REG_DATA, i);
        bus_rd(REG_LVL, lvl);
        bus_rd(REG_LSR, lsr);
      end
      begin
        for (int i = 0; i < 18; i++) tx_decode(16, got[i], t[i], ok[i]);
      end
    join
    chk_cnt++;
    if (lvl[15:0] !== 16'd16) $display("FAIL ovf_tx_count: got %0d exp 16", lvl[15:0]);
    else pass_cnt++;
    chk_cnt++;
    if (lsr[LSR_TXFULL] !== 1'b1) $display("FAIL ovf_tx_full: lsr=%h exp bit4", lsr);
    else pass_cnt++;
    for (int i = 0; i < 17; i++) begin
      chk_cnt++;
      if (!ok[i] || got[i] !== 8'(i))
        $display("FAIL ovf_char%0d: got %h ok=%b exp %h", i, got[i], ok[i], 8'(i));
      else pass_cnt++;
    end
    chk_cnt++;
    if (ok[17]) $display("FAIL ovf_dropped: got extra char %h exp none", got[17]);
    else pass_cnt++;
    gaps = 0;
    for (int i = 0; i < 16; i++) if (t[i + 1] - t[i] != 160) gaps++;
    chk_cnt++;
    if (gaps !== 0) $display("FAIL ovf_back_to_back: %0d gaps exp 0", gaps);
    else pass_cnt++;
  endtask

  task automatic test_rx_random();
    logic [7:0] exp_q[$];
    logic [7:0] v;
    logic [31:0] r;
    bus_rd(REG_LSR, r);
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom);
      exp_q.push_back(v);
      send_rx(v, 1'b1, 16);
    end
    bus_rd(REG_LVL, r);
    chk_cnt++;
    if (r[31:16] !== 16'd6) $display("FAIL rx_count: got %0d exp 6", r[31:16]);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      bus_rd(REG_DATA, r);
      chk_cnt++;
      if (r !== {24'h0, exp_q[i]})
        $display("FAIL rx_rand%0d: got %h exp %h", i, r, exp_q[i]);
      else pass_cnt++;
    end
    bus_rd(REG_LSR, r);
    chk_cnt++;
    if (r[LSR_RXNE] !== 1'b0) $display("FAIL rx_drained: lsr=%h exp bit0 clear", r);
    else pass_cnt++;
  endtask

  task automatic test_rx_overrun();
    logic [7:0] q[$];
    logic [7:0] v;
    logic [31:0] r;
    logic oe_exp;
    oe_exp = 1'b0;
    for (int i = 0; i < 17; i++) begin
      v = 8'($urandom);
      if (q.size() < 16) q.push_back(v);
      else oe_exp = 1'b1;
      send_rx(v, 1'b1, 16);
    end
    bus_rd(REG_LVL, r);
    chk_cnt++;
    if (r[31:16] !== 16'(q.size())) $display("FAIL oe_rx_count: got %0d exp %0d", r[31:16], q.size());
    else pass_cnt++;
    bus_rd(REG_LSR, r);
    chk_cnt++;
    if (r[LSR_OE] !== oe_exp) $display("FAIL oe_set: got %b exp %b", r[LSR_OE], oe_exp);
    else pass_cnt++;
    bus_rd(REG_LSR, r);
    chk_cnt++;
    if (r[LSR_OE] !== 1'b0) $display("FAIL oe_clear: got %b exp 0", r[LSR_OE]);
    else pass_cnt++;
    while (q.size() > 0) begin
      v = q.pop_front();
      bus_rd(REG_DATA, r);
      chk_cnt++;
      if (r !== {24'h0, v}) $display("FAIL oe_drain: got %h exp %h", r, v);
      else pass_cnt++;
    end
  endtask

  task automatic test_frame_glitch();
    logic [31:0] r;
    send_rx(8'($urandom), 1'b0, 16);
    bus_rd(REG_LSR, r);
    chk_cnt++;
    if (r[LSR_FE] !== 1'b1 || r[LSR_RXNE] !== 1'b0)
      $display("FAIL fe_set: lsr=%h exp fe=1 rxne=0", r);
    else pass_cnt++;
    bus_rd(REG_LVL, r);
    chk_cnt++;
    if (r[31:16] !== 16'd0) $display("FAIL fe_count: got %0d exp 0", r[31:16]);
    else pass_cnt++;
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    bus_rd(REG_LSR, r);
    chk_cnt++;
    if (r[LSR_FE] !== 1'b0 || r[LSR_RXNE] !== 1'b0)
      $display("FAIL glitch: lsr=%h exp fe=0 rxne=0", r);
    else pass_cnt++;
  endtask

  task automatic test_irq();
    logic [31:0] r;
    bus_wr(REG_IER, 32'h1);
    @(negedge clk);
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_quiet: got %b exp 0", irq);
    else pass_cnt++;
    send_rx(8'h3C, 1'b1, 16);
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_rx: got %b exp 1", irq);
    else pass_cnt++;
    bus_rd(REG_DATA, r);
    chk_cnt++;
    if (r !== 32'h3C) $display("FAIL irq_data: got %h exp 3c", r);
    else pass_cnt++;
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_latency: got %b exp 1", irq);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_clear: got %b exp 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] r;
    int n;
    bus_wr(REG_DIV, 32'd16);
    for (int i = 0; i < 3; i++) bus_wr(REG_DATA, 32'h0);
    n = 0;
    while (txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (24) @(negedge clk);
    chk_cnt++;
    if (txd !== 1'b0) $display("FAIL mid_tx_low: txd=%b exp 0", txd);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (txd !== 1'b1 || irq !== 1'b0)
      $display("FAIL rst_txd: txd=%b irq=%b exp 1/0", txd, irq);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bus_rd(REG_LVL, r);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL rst_lvl: got %h exp 0", r);
    else pass_cnt++;
    bus_rd(REG_DIV, r);
    chk_cnt++;
    if (r !== 32'd5208) $display("FAIL rst_div: got %0d exp 5208", r);
    else pass_cnt++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: no finish by 2ms exp done");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx_pattern();
    test_tx_random();
    test_tx_overflow();
    test_rx_random();
    test_rx_overrun();
    test_frame_glitch();
    test_irq();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
